// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the inter-stage pipeline register: occupancy state encoding.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKIDF = 2'd2
    } ps_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between two stages, with optional 2-entry skid,
// synchronous bubble-inserting flush and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned      WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             psi_clk,
    input  logic             psi_rst,
    input  logic             psi_flush,
    input  logic             psi_valid,
    input  logic [WIDTH-1:0] psi_data,
    output logic             pso_up_ready,
    output logic             pso_valid,
    output logic [WIDTH-1:0] pso_data,
    input  logic             psi_dn_ready,
    output logic [CNT_W-1:0] pso_stall_cnt
);

    ps_state_e        state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign pso_valid = (state_q != PS_EMPTY);
    assign pso_data  = main_q;
    assign in_fire   = psi_valid & pso_up_ready;
    assign out_fire  = pso_valid & psi_dn_ready;

    // Registers only ever load psi_data on in_fire, so X on an idle bus never gets in.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (psi_flush) begin
            state_d = PS_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        state_d = PS_FULL;
                        main_d  = psi_data;
                    end
                end
                PS_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = psi_data;
                    end else if (SKID && in_fire) begin
                        state_d = PS_SKIDF;
                        skid_d  = psi_data;
                    end else if (out_fire) begin
                        state_d = PS_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                PS_SKIDF: begin
                    if (out_fire) begin
                        state_d = PS_FULL;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge psi_clk or negedge psi_rst) begin
        if (!psi_rst) begin
            state_q <= PS_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // With the skid entry, upstream ready is a flop so psi_dn_ready never reaches it.
    generate
        if (SKID) begin : g_skid_ready
            logic up_ready_q;
            logic up_ready_d;
            assign up_ready_d = (state_d != PS_SKIDF);
            always_ff @(posedge psi_clk or negedge psi_rst) begin
                if (!psi_rst) begin
                    up_ready_q <= 1'b1;
                end else begin
                    up_ready_q <= up_ready_d;
                end
            end
            assign pso_up_ready = up_ready_q;
        end else begin : g_comb_ready
            assign pso_up_ready = ~pso_valid | psi_dn_ready;
        end
    endgenerate

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (psi_clk),
        .rst_n(psi_rst),
        .inc  (pso_valid & ~psi_dn_ready),
        .cnt  (pso_stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid instance.
module tb_pipe_stage_reg;

    localparam logic [63:0] A_BUBBLE = 64'hB0B0;
    localparam logic [15:0] B_BUBBLE = 16'h0000;

    logic        clk;
    logic        rst_n;

    logic        a_flush, a_valid, a_dn_ready;
    logic [63:0] a_data;
    logic        a_up_ready, a_ovalid;
    logic [63:0] a_odata;
    logic [3:0]  a_stall;

    logic        b_flush, b_valid, b_dn_ready;
    logic [15:0] b_data;
    logic        b_up_ready, b_ovalid;
    logic [15:0] b_odata;
    logic [15:0] b_stall;

    int n_cmp;
    int n_err;

    logic [63:0] qa[$];
    logic [15:0] qb[$];

    pipe_stage_reg #(
        .WIDTH (64),
        .BUBBLE(A_BUBBLE),
        .SKID  (1'b1),
        .CNT_W (4)
    ) u_dut_a (
        .psi_clk      (clk),
        .psi_rst      (rst_n),
        .psi_flush    (a_flush),
        .psi_valid    (a_valid),
        .psi_data     (a_data),
        .pso_up_ready (a_up_ready),
        .pso_valid    (a_ovalid),
        .pso_data     (a_odata),
        .psi_dn_ready (a_dn_ready),
        .pso_stall_cnt(a_stall)
    );

    pipe_stage_reg #(
        .WIDTH (16),
        .BUBBLE(B_BUBBLE),
        .SKID  (1'b0),
        .CNT_W (16)
    ) u_dut_b (
        .psi_clk      (clk),
        .psi_rst      (rst_n),
        .psi_flush    (b_flush),
        .psi_valid    (b_valid),
        .psi_data     (b_data),
        .pso_up_ready (b_up_ready),
        .pso_valid    (b_ovalid),
        .pso_data     (b_odata),
        .psi_dn_ready (b_dn_ready),
        .pso_stall_cnt(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: push on accepted beat, pop on delivered beat; flush drops what is held.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
        end else begin
            if (a_ovalid === 1'b0) check_eq("a_bubble", a_odata, A_BUBBLE);
            if (a_ovalid && a_dn_ready) begin
                if (qa.size() == 0) check_eq("a_sb_extra", 64'(qa.size()), 64'd1);
                else check_eq("a_sb_order", a_odata, qa.pop_front());
            end
            if (a_flush) qa.delete();
            else if (a_valid && a_up_ready) qa.push_back(a_data);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
        end else begin
            if (b_ovalid === 1'b0) check_eq("b_bubble", 64'(b_odata), 64'(B_BUBBLE));
            if (b_ovalid && b_dn_ready) begin
                if (qb.size() == 0) check_eq("b_sb_extra", 64'(qb.size()), 64'd1);
                else check_eq("b_sb_order", 64'(b_odata), 64'(qb.pop_front()));
            end
            if (b_flush) qb.delete();
            else if (b_valid && b_up_ready) qb.push_back(b_data);
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_flush = 1'b0; a_valid = 1'b1; a_data = 64'hA5; a_dn_ready = 1'b1;
        b_flush = 1'b0; b_valid = 1'b0; b_data = 16'h0;  b_dn_ready = 1'b1;
        #12;
        check_eq("rst_valid", a_ovalid, 1'b0);
        check_eq("rst_data", a_odata, A_BUBBLE);
        check_eq("rst_ready", a_up_ready, 1'b1);
        check_eq("rst_stall", 64'(a_stall), 64'd0);
        check_eq("rst_b_ready", b_up_ready, 1'b1);
        a_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Back-to-back stream, one-cycle latency, no bubbles
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1'b1; a_data = 64'(i);
            step();
            check_eq("stream_valid", a_ovalid, 1'b1);
            check_eq("stream_data", a_odata, 64'(i));
        end
        a_valid = 1'b0;
        step();
        check_eq("stream_drain", a_ovalid, 1'b0);

        // Skid fill while downstream stalled
        a_dn_ready = 1'b0;
        a_valid = 1'b1; a_data = 64'd7;
        step();
        check_eq("skid_v7", a_ovalid, 1'b1);
        check_eq("skid_d7", a_odata, 64'd7);
        check_eq("skid_rdy7", a_up_ready, 1'b1);
        a_data = 64'd8;
        step();
        check_eq("skid_rdy8", a_up_ready, 1'b0);
        check_eq("skid_hold7", a_odata, 64'd7);
        check_eq("skid_stall1", 64'(a_stall), 64'd1);
        a_data = 64'd9;
        step();
        check_eq("skid_rdy9", a_up_ready, 1'b0);
        check_eq("skid_stall2", 64'(a_stall), 64'd2);
        a_dn_ready = 1'b1;
        step();
        check_eq("skid_out8", a_odata, 64'd8);
        check_eq("skid_rdy_back", a_up_ready, 1'b1);
        step();
        check_eq("skid_out9", a_odata, 64'd9);
        a_valid = 1'b0;
        step();
        check_eq("skid_empty", a_ovalid, 1'b0);
        check_eq("skid_stall_tot", 64'(a_stall), 64'd2);

        // Flush while SKIDF with a new beat presented
        a_dn_ready = 1'b0;
        a_valid = 1'b1; a_data = 64'd7;
        step();
        a_data = 64'd8;
        step();
        check_eq("fl_pre_rdy", a_up_ready, 1'b0);
        a_data = 64'd9; a_flush = 1'b1;
        step();
        a_flush = 1'b0; a_valid = 1'b0; a_dn_ready = 1'b1;
        check_eq("fl_valid", a_ovalid, 1'b0);
        check_eq("fl_data", a_odata, A_BUBBLE);
        check_eq("fl_rdy", a_up_ready, 1'b1);
        check_eq("fl_stall_kept", 64'(a_stall), 64'd4);
        step();
        check_eq("fl_no9", a_ovalid, 1'b0);
        a_valid = 1'b1; a_data = 64'd10;
        step();
        check_eq("fl_next", a_odata, 64'd10);
        a_valid = 1'b0;
        step();

        // Stall counter saturation at 15
        a_dn_ready = 1'b0;
        a_valid = 1'b1; a_data = 64'h55;
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check_eq("sat_reach", 64'(a_stall), 64'd15);
        for (int i = 0; i < 9; i++) step();
        check_eq("sat_hold", 64'(a_stall), 64'd15);
        check_eq("sat_data", a_odata, 64'h55);
        a_dn_ready = 1'b1;
        step();

        // Asynchronous reset in the middle of a transfer
        a_dn_ready = 1'b0;
        a_valid = 1'b1; a_data = 64'h66;
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst_valid", a_ovalid, 1'b0);
        check_eq("mrst_data", a_odata, A_BUBBLE);
        check_eq("mrst_stall", 64'(a_stall), 64'd0);
        a_valid = 1'b0; a_dn_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        check_eq("mrst_after", a_ovalid, 1'b0);

        // No-skid instance: ready follows psi_dn_ready combinationally
        b_dn_ready = 1'b0;
        b_valid = 1'b1; b_data = 16'h11;
        step();
        check_eq("b_fill_v", b_ovalid, 1'b1);
        check_eq("b_rdy_lo", b_up_ready, 1'b0);
        b_dn_ready = 1'b1; #1;
        check_eq("b_rdy_hi", b_up_ready, 1'b1);
        b_dn_ready = 1'b0; #1;
        check_eq("b_rdy_lo2", b_up_ready, 1'b0);
        begin
            logic [15:0] nxt;
            nxt = 16'h21;
            for (int i = 0; i < 8; i++) begin
                b_dn_ready = (i % 2 == 1); b_valid = 1'b1; b_data = nxt;
                #1;
                check_eq("b_rdy_follow", b_up_ready, (i % 2 == 1));
                step();
                if (i % 2 == 1) nxt = nxt + 16'd1;
            end
        end
        check_eq("b_stall", 64'(b_stall), 64'd4);
        b_valid = 1'b0; b_dn_ready = 1'b1;
        step();
        check_eq("b_drain", b_ovalid, 1'b0);
        step();

        check_eq("a_sb_left", 64'(qa.size()), 64'd0);
        check_eq("b_sb_left", 64'(qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers.
- Carries one opaque payload bus of WIDTH bits between two pipeline stages.
- Replaces the enable/keep pins with a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush that inserts a bubble, and a saturating stall-cycle counter.
- Instantiated between every pair of stages: IF/ID, ID/EXE, EXE/MEM and MEM/WB.

Parameters:
WIDTH, 64, payload width in bits (>=1)
BUBBLE, {WIDTH{1'b0}}, payload value presented while empty/flushed (e.g. encodes REG_INVALID, RWE_IDLE)
SKID, 1, 1 = 2-entry skid buffer with registered upstream ready; 0 = single entry, combinational ready
CNT_W, 16, stall counter width

Ports:
psi_clk  input  1  clock, rising edge
psi_rst  input  1  asynchronous reset, active low
psi_flush  input  1  synchronous flush; discards all held and incoming beats
psi_valid  input  1  upstream beat valid
psi_data  input  WIDTH  upstream payload
pso_up_ready  output  1  stage can accept a beat this cycle
pso_valid  output  1  downstream beat valid
pso_data  output  WIDTH  downstream payload
psi_dn_ready  input  1  downstream accepts beat
pso_stall_cnt  output  CNT_W  cycles with pso_valid=1 and psi_dn_ready=0, saturating

Behaviour:
- Reset (psi_rst=0, asynchronous):
  - state=EMPTY, main register=BUBBLE, skid register=BUBBLE.
  - pso_valid=0, pso_data=BUBBLE, pso_stall_cnt=0.
  - pso_up_ready=1 when SKID=1; equal to ~pso_valid|psi_dn_ready (i.e. 1) when SKID=0.
- Definitions: in_fire = psi_valid & pso_up_ready; out_fire = pso_valid & psi_dn_ready.
- Outputs are registered: pso_valid = (state != EMPTY); pso_data = main register.
- Latency: 1 cycle from in_fire to pso_valid when EMPTY.
- Invariant: pso_data == BUBBLE whenever pso_valid=0.
- States and transitions (SKID=1):
  - EMPTY: in_fire -> FULL, main<=psi_data.
  - FULL:
    - in_fire & out_fire -> FULL, main<=psi_data.
    - in_fire & !out_fire -> SKIDF, skid<=psi_data.
    - !in_fire & out_fire -> EMPTY, main<=BUBBLE.
    - otherwise hold.
  - SKIDF: pso_up_ready=0, so no in_fire. out_fire -> FULL, main<=skid, skid<=BUBBLE; else hold.
  - pso_up_ready is a register: 1 in EMPTY/FULL, 0 in SKIDF. No combinational path from psi_dn_ready.
- SKID=0:
  - SKIDF state does not exist.
  - pso_up_ready = ~pso_valid | psi_dn_ready (combinational).
  - FULL with in_fire & !out_fire cannot occur.
- Flush has highest priority, evaluated at the clock edge:
  - next state=EMPTY, main<=BUBBLE, skid<=BUBBLE.
  - A beat presented the same cycle is dropped; in_fire is ignored even if pso_up_ready=1.
  - A beat with out_fire the same cycle counts as delivered.
- Ordering: strict FIFO; no beat is duplicated or lost except by flush.
- Stall counter:
  - increments when pso_valid & ~psi_dn_ready; holds at 2^CNT_W-1.
  - not cleared by flush; cleared only by reset.
- Reset mid-transfer: all beats discarded immediately, no partial output.
- X on psi_data while psi_valid=0 must never propagate into the main or skid registers.

Decomposition:
- defines.v: state encodings `PS_EMPTY=2'd0, `PS_FULL=2'd1, `PS_SKIDF=2'd2.
- defines.v: per-stage bubble patterns (`ID_EXE_BUBBLE etc.) built from the existing REG_INVALID and RWE_IDLE constants.
- One natural sub-module: sat_counter (parameter W; inc, clk, rst ports) for the stall counter.

Test Plan:
- Reset with psi_valid=1, psi_data=64'hA5 -> pso_valid=0, pso_data=BUBBLE, pso_up_ready=1, pso_stall_cnt=0.
- Stream 1,2,3,4 with psi_dn_ready=1 -> pso_data 1,2,3,4 on consecutive cycles, one cycle after each input; no bubbles.
- SKID=1: hold psi_dn_ready=0 while sending 7,8,9 -> 7,8 accepted, pso_up_ready=0 the cycle after 8. Release ready -> outputs 7,8, then 9; pso_stall_cnt equals the stalled cycles.
- Flush while in SKIDF holding 7,8 with psi_valid=1 data 9 -> next cycle pso_valid=0, pso_data=BUBBLE; 9 never appears.
- CNT_W=4, psi_dn_ready=0 for 20 cycles with pso_valid=1 -> pso_stall_cnt saturates at 15.
- SKID=0: pso_valid=1, psi_dn_ready toggles 0/1 -> pso_up_ready follows psi_dn_ready in the same cycle; data order preserved.
